// File: rtl/regdump_pkg.sv
// Shared definitions for the register dump sweeper and its RegFile neighbour.
package regdump_pkg;

   localparam int W_DEF = 8;   // RegFile data width
   localparam int A_DEF = 3;   // RegFile address width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Beat stream carrying (address, data) pairs out of the dump sweeper.
interface reg_dump_reader_if
   import regdump_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int A = A_DEF
);
   logic         OutValid;
   logic         OutReady;
   logic [A-1:0] OutAddr;
   logic [W-1:0] OutData;
   logic         OutLast;

   modport master (output OutValid, OutAddr, OutData, OutLast, input OutReady);
   modport slave  (input  OutValid, OutAddr, OutData, OutLast, output OutReady);
endinterface

// File: rtl/reg_dump_reader.sv
// Sweeps every RegFile entry through one read port, streams (addr, data)
// beats with valid/ready, and accumulates a mod-2**W checksum.
module reg_dump_reader
   import regdump_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int A = A_DEF
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Start,
   output logic [A-1:0]             RdAddr,
   input  logic [W-1:0]             RdData,
   reg_dump_reader_if.master        dump,
   output logic                     Busy,
   output logic                     Done,
   output logic [W-1:0]             Checksum
);

   localparam logic [A-1:0] LAST_IDX = '1;

   state_t       state;
   logic [A-1:0] idx;

   // Single FSM: index counter, read address, beat register and checksum.
   // RdAddr is registered one step ahead so it already equals idx in LOAD,
   // giving the RegFile a full cycle to return RdData.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= IDLE;
         idx           <= '0;
         RdAddr        <= '0;
         dump.OutValid <= 1'b0;
         dump.OutAddr  <= '0;
         dump.OutData  <= '0;
         dump.OutLast  <= 1'b0;
         Busy          <= 1'b0;
         Done          <= 1'b0;
         Checksum      <= '0;
      end else begin
         case (state)
            // DONE holds Done/Checksum until a new Start, which re-sweeps from 0
            IDLE, DONE: begin
               if (Start) begin
                  state    <= LOAD;
                  idx      <= '0;
                  RdAddr   <= '0;
                  Checksum <= '0;
                  Busy     <= 1'b1;
                  Done     <= 1'b0;
               end
            end
            LOAD: begin
               dump.OutData  <= RdData;
               dump.OutAddr  <= idx;
               dump.OutLast  <= (idx == LAST_IDX);
               dump.OutValid <= 1'b1;
               state         <= SEND;
            end
            // Beat held stable until accepted; Start is ignored mid-sweep
            SEND: begin
               if (dump.OutReady) begin
                  Checksum      <= Checksum + dump.OutData;
                  dump.OutValid <= 1'b0;
                  if (dump.OutLast) begin
                     state <= DONE;
                     Busy  <= 1'b0;
                     Done  <= 1'b1;
                  end else begin
                     idx    <= idx + 1'b1;
                     RdAddr <= idx + 1'b1;
                     state  <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: full sweeps, backpressure, checksum
// wrap, ignored Start, restart and mid-sweep reset.
module tb_reg_dump_reader;
   import regdump_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Start;
   logic [2:0] RdAddr;
   logic [7:0] RdData;
   logic       Busy;
   logic       Done;
   logic [7:0] Checksum;

   logic [7:0] rf [8];
   int         total = 0;
   int         bad   = 0;
   string      phase = "init";

   reg_dump_reader_if #(.W(8), .A(3)) dump ();

   reg_dump_reader #(.W(8), .A(3)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .RdAddr   (RdAddr),
      .RdData   (RdData),
      .dump     (dump),
      .Busy     (Busy),
      .Done     (Done),
      .Checksum (Checksum)
   );

   always #5 Clk = ~Clk;

   assign RdData = rf[RdAddr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // RegFile write from the core side; must never happen while sweeping
   task automatic rf_write(input int a, input logic [7:0] d);
      chk("wr_while_busy", Busy, 1'b0);
      rf[a] = d;
   endtask

   task automatic rf_fill(input logic [7:0] base, input logic [7:0] step);
      for (int i = 0; i < 8; i++) rf_write(i, base + step * 8'(i));
   endtask

   // mode 0: OutReady held high; mode 1: OutReady 0,0,1 per beat
   task automatic sweep(input int mode, input int restart_at, input logic [7:0] exp_cs);
      int         cyc, beat, pat;
      bit         stalled;
      logic [2:0] ha;
      logic [7:0] hd;
      logic       hl;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("busy_rise", Busy, 1'b1);
      chk("done_clr", Done, 1'b0);
      chk("cs_clr", Checksum, 8'h00);
      cyc = 0; beat = 0; pat = 0; stalled = 0;
      while (!Done && cyc < 400) begin
         Start = 1'b0;
         dump.OutReady = (mode == 0) ? 1'b1 : (pat == 2);
         chk("busy_hold", Busy, 1'b1);
         if (dump.OutValid) begin
            if (stalled) begin
               chk("stall_addr", dump.OutAddr, ha);
               chk("stall_data", dump.OutData, hd);
               chk("stall_last", dump.OutLast, hl);
            end else begin
               chk("beat_addr", dump.OutAddr, beat[2:0]);
               chk("beat_data", dump.OutData, rf[beat[2:0]]);
               chk("beat_last", dump.OutLast, beat == 7);
               if (beat == restart_at) Start = 1'b1;
            end
            ha = dump.OutAddr; hd = dump.OutData; hl = dump.OutLast;
            if (dump.OutReady) begin
               beat++; pat = 0; stalled = 0;
            end else begin
               pat++; stalled = 1;
            end
         end else begin
            chk("rdaddr", RdAddr, beat[2:0]);
         end
         tick();
         cyc++;
      end
      Start = 1'b0;
      chk("sweep_timeout", Done, 1'b1);
      chk("beat_count", beat, 8);
      chk("checksum", Checksum, exp_cs);
      chk("busy_fall", Busy, 1'b0);
      chk("valid_fall", dump.OutValid, 1'b0);
      if (mode == 0) chk("sweep_cycles", cyc, 16);
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; dump.OutReady = 1'b0;
      for (int i = 0; i < 8; i++) rf[i] = 8'h00;
      tick(); tick();
      Reset = 1'b0;

      phase = "reset";
      chk("valid", dump.OutValid, 1'b0);
      chk("addr", dump.OutAddr, 3'd0);
      chk("data", dump.OutData, 8'h00);
      chk("last", dump.OutLast, 1'b0);
      chk("rdaddr", RdAddr, 3'd0);
      chk("busy", Busy, 1'b0);
      chk("done", Done, 1'b0);
      chk("cs", Checksum, 8'h00);
      tick();
      chk("idle_busy", Busy, 1'b0);

      phase = "basic";
      rf_fill(8'h10, 8'h01);
      sweep(0, -1, 8'h9C);

      phase = "hold";
      repeat (3) tick();
      chk("done_hold", Done, 1'b1);
      chk("cs_hold", Checksum, 8'h9C);
      chk("busy_idle", Busy, 1'b0);

      phase = "backpressure";
      sweep(1, 3, 8'h9C);

      phase = "ignored_start";
      sweep(0, 3, 8'h9C);

      phase = "restart";
      rf_write(5, 8'h00);
      sweep(0, -1, 8'h87);

      phase = "all_ff";
      rf_fill(8'hFF, 8'h00);
      sweep(0, -1, 8'hF8);

      phase = "all_zero";
      rf_fill(8'h00, 8'h00);
      sweep(0, -1, 8'h00);

      phase = "reset_mid";
      rf_fill(8'h10, 8'h01);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      begin
         int n = 0;
         dump.OutReady = 1'b1;
         while (!(dump.OutValid && dump.OutAddr == 3'd4) && n < 50) begin
            tick();
            n++;
         end
      end
      chk("reach_beat4", dump.OutValid && dump.OutAddr == 3'd4, 1'b1);
      chk("cs_partial", Checksum, 8'h46);
      dump.OutReady = 1'b0;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("valid", dump.OutValid, 1'b0);
      chk("busy", Busy, 1'b0);
      chk("done", Done, 1'b0);
      chk("cs", Checksum, 8'h00);
      phase = "after_reset";
      sweep(0, -1, 8'h9C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side sweeper for the RegFile: on request, walks every register through one read port and streams (address, data) beats out over a valid/ready handshake.
- Used at program end to dump architectural state to the testbench/host or to a data-memory writer, and accumulates a modular checksum of all register contents.
- Holds Busy high while sweeping so the core stalls register writes; the snapshot is therefore coherent.

Parameters:
- W, 8, data path width (matches RegFile W)
- A, 3, register address width; sweep covers 2**A registers

Ports:
- Clk       input   1    clock
- Reset     input   1    synchronous, active-high reset
- Start     input   1    single-cycle request to begin a sweep
- RdAddr    output  A    register read address, driven to a RegFile read port
- RdData    input   W    combinational read data returned for RdAddr
- OutValid  output  1    beat valid
- OutReady  input   1    downstream accepts beat
- OutAddr   output  A    register index of the current beat
- OutData   output  W    register contents of the current beat
- OutLast   output  1    high with OutValid on the final beat (index 2**A-1)
- Busy      output  1    sweep in progress; core must suppress RegFile WriteEn
- Done      output  1    level; sweep completed and Checksum is valid
- Checksum  output  W    sum mod 2**W of all accepted OutData beats

Behaviour:
- Clocking: one clock (Clk); reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: state IDLE; idx=0; RdAddr=0; OutValid=0; OutAddr=0; OutData=0; OutLast=0; Busy=0; Done=0; Checksum=0.
- States: IDLE, LOAD, SEND, DONE.
- IDLE:
  - Start=1 -> LOAD; idx<=0; Checksum<=0; Busy<=1.
- LOAD (one cycle):
  - RdAddr=idx.
  - At the clock edge, OutData<=RdData, OutAddr<=idx, OutLast<=(idx==2**A-1), OutValid<=1 -> SEND.
  - Read latency is 1 cycle.
- SEND:
  - OutValid=1. OutAddr, OutData and OutLast stay stable while OutReady=0; wait indefinitely.
  - On OutValid&&OutReady: Checksum<=Checksum+OutData, truncated to W bits, and OutValid<=0.
  - If OutLast, go to DONE with Busy<=0 and Done<=1. Otherwise idx<=idx+1 and go to LOAD.
- Throughput: at most one beat every 2 cycles. A full sweep with OutReady held high takes 2*2**A cycles from Start to Done.
- DONE:
  - Done=1 and Checksum hold until the next Start or Reset.
  - Start=1 -> Done<=0, then as in IDLE, so a restart re-sweeps from idx 0.
- Start while in LOAD or SEND is ignored; no queuing.
- idx never wraps during a sweep; it terminates at 2**A-1. Sweep order is strictly ascending 0..2**A-1, every register exactly once.
- Reset mid-sweep (any state): next cycle is IDLE with reset values. A partially transferred beat is dropped; OutValid drops with no handshake.
- RdAddr holds its last value outside LOAD. Consumers must not rely on it.
- Busy rises the cycle after Start is accepted and falls in the same cycle Done rises.
- Contract with the core: the core must gate WriteEn and LUTen writes while Busy=1. No write-hazard detection is done here.

Decomposition:
- Shared package (regdump_pkg): state enum typedef {IDLE, LOAD, SEND, DONE}; defaults W=8 and A=3 shared with RegFile.
- No sub-module is natural. The FSM, index counter, output register and checksum accumulator stay in one module.

Test Plan:
- Reset, registers r0..r7 loaded with 8'h10..8'h17, pulse Start, OutReady=1 -> 8 beats with OutAddr 0..7 and OutData 10..17, OutLast only on addr 7. Done rises at cycle 16 after Start. Checksum=8'h9C.
- Backpressure: same register contents, OutReady toggling 0,0,1 repeatedly -> OutData/OutAddr stable across stalled cycles, no beat duplicated or skipped, final Checksum=8'h9C.
- Checksum wrap: all registers 8'hFF -> Checksum=8'hF8 (2040 mod 256); all registers 0 -> Checksum=0 and Done=1.
- Start ignored/restart: Start pulsed again mid-sweep at beat 3 -> sweep continues unchanged. After Done, change r5 to 8'h00 and pulse Start -> Done drops, new sweep, Checksum=8'h87.
- Reset mid-sweep: Reset during SEND at beat 4 with OutReady=0 -> next cycle OutValid=0, Busy=0, Done=0, Checksum=0. A subsequent Start yields a full 8-beat sweep from addr 0.
- Busy timing: Busy=0 in IDLE, 1 from the cycle after Start through the last handshake, 0 in DONE. The bench asserts no RegFile write occurs while Busy=1.
